vga_layer_compositor: RTL and testbench
=======================================

Name: vga_layer_compositor

Overview:
- Parametrised successor to the fixed 13-input pixel mux with its 3 s black mask.
- Composites NUM_LAYERS sprite/tile layers by fixed priority, with per-layer runtime enable.
- Replaces the hard mask with a power-up hold followed by a stepped brightness fade FSM: fade-in, on, fade-out, off, re-fade-in.
- Drives rgb_out to the VGA DAC pins through a 2-stage registered pipeline.

Parameters:
- NUM_LAYERS, 16, number of input layers; index 0 = highest priority.
- COLOR_W, 12, pixel width, 4 bits per channel, R[11:8] G[7:4] B[3:0].
- HOLD_CYCLES, 75_000_000, black hold after reset (3 s at 25 MHz).
- FADE_STEP_CYCLES, 1_562_500, clocks per brightness step (16 steps = 1 s).
- COLOR_KEY, 12'hF0F, transparent key colour (used only with the optional feature).

Ports:
- clk  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-high.
- layer_rgb  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i at [i*COLOR_W +: COLOR_W].
- layer_drawing  in  NUM_LAYERS  layer i has a pixel at the current position.
- layer_enable  in  NUM_LAYERS  runtime mask; 0 = layer hidden.
- video_on  in  1  active-area flag from the timing generator.
- fade_in_req  in  1  single-cycle pulse.
- fade_out_req  in  1  single-cycle pulse.
- rgb_out  out  COLOR_W  composited, scaled pixel.
- layer_sel  out  $clog2(NUM_LAYERS+1)  winning layer index; NUM_LAYERS = background. Aligned with rgb_out.
- fade_state  out  3  current FSM state (fade_state_t encoding).
- fade_busy  out  1  high in HOLD, FADE_IN and FADE_OUT.

Behaviour:
- Reset values:
  - rgb_out = 0.
  - layer_sel = NUM_LAYERS.
  - fade_state = HOLD.
  - fade_busy = 1.
  - level = 0; all counters = 0.
- Stage 1 (registered): winner = lowest i with layer_drawing[i] & layer_enable[i].
  - If a winner exists: latch its colour and index.
  - If none: colour = BLACK, index = NUM_LAYERS.
  - video_on is registered alongside.
- Stage 2 (registered): each 4-bit channel c -> (c*level)>>4, with level 0..16 (5-bit).
  - level 16 is exact pass-through; level 0 gives black.
  - If the stage-1 video_on copy is 0, rgb_out = 0.
- Latency: input to rgb_out/layer_sel = 2 clk. fade_state/fade_busy are direct FSM register outputs (0 pipeline delay).
- Level changes take effect at stage 2 only; no mid-pixel tearing concern.
- FSM states: HOLD, FADE_IN, ON, FADE_OUT, OFF.
  - HOLD: level 0; counts to HOLD_CYCLES-1, then goes to FADE_IN. All requests ignored.
  - FADE_IN: level +1 every FADE_STEP_CYCLES; on reaching 16, go to ON. fade_out_req -> FADE_OUT from the current level; step counter cleared.
  - ON: level 16. fade_out_req -> FADE_OUT; fade_in_req ignored.
  - FADE_OUT: level -1 every FADE_STEP_CYCLES; on reaching 0, go to OFF. fade_in_req -> FADE_IN from the current level; step counter cleared.
  - OFF: level 0. fade_in_req -> FADE_IN; fade_out_req ignored.
- Simultaneous requests: if both pulses arrive in one cycle, fade_out_req wins.
- Saturation: level never wraps; it is clamped to 0..16.
- Reset mid-fade: returns to HOLD, level 0, rgb_out black on the next edge.
- Counter width: $clog2(max(HOLD_CYCLES, FADE_STEP_CYCLES)). Counter restarts from 0 on every state change.

Optional Feature:
- Macro: VGA_COMPOSITOR_COLORKEY_EN.
- Defined: a layer whose colour equals COLOR_KEY is treated as not drawing, so priority falls through to the next layer. Applies to the stage-1 decision only.
- Undefined: only layer_drawing & layer_enable decide; COLOR_KEY is unused and a key-coloured pixel is displayed as-is.

Decomposition:
- Package utils holds:
  - color_t (12-bit).
  - BLACK constant.
  - fade_state_t enum {HOLD, FADE_IN, ON, FADE_OUT, OFF}.
  - LEVEL_MAX = 16.
- Sub-module vga_fade_ctrl contains the FSM, counter and level register, and outputs level, fade_state and fade_busy.
- The top level holds the priority encoder and the two pipeline stages.

Test Plan (bench uses HOLD_CYCLES=10, FADE_STEP_CYCLES=2, NUM_LAYERS=4):
- Reset deassert with all layers drawing 12'hFFF:
  - rgb_out = 0 and fade_state = HOLD for 10 clk.
  - Then level rises 1 per 2 clk.
  - At level 16, fade_state = ON and rgb_out = 12'hFFF.
- In ON, layers 1 and 3 drawing (12'h0F0, 12'h00F): rgb_out = 12'h0F0, layer_sel = 1, both 2 clk later. Clear layer_enable[1]: rgb_out = 12'h00F, layer_sel = 3.
- In ON, layer 0 = 12'hF80, pulse fade_out_req: at level 8, rgb_out = 12'h740. At level 0, fade_state = OFF and rgb_out = 0.
- Pulse fade_out_req at FADE_IN level 6: next state FADE_OUT, level goes 6 -> 5 after 2 clk, no jump.
- Assert both requests in the same cycle during FADE_IN: FSM enters FADE_OUT.
- video_on low in ON: rgb_out = 0 exactly 2 clk later.
- With VGA_COMPOSITOR_COLORKEY_EN, layer 0 = 12'hF0F and layer 2 = 12'h123: rgb_out = 12'h123, layer_sel = 2.
- Reset asserted mid-FADE_OUT: state returns to HOLD, rgb_out = 0.

Source files
------------

// File: rtl/vga_layer_compositor_pkg.sv
// Shared types and constants for the VGA layer compositor and its fade controller.
package vga_layer_compositor_pkg;

    typedef logic [11:0] color_t;
    typedef logic [4:0]  level_t;

    localparam color_t BLACK     = 12'h000;
    localparam level_t LEVEL_MAX = 5'd16;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        FADE_IN  = 3'd1,
        ON       = 3'd2,
        FADE_OUT = 3'd3,
        OFF      = 3'd4
    } fade_state_t;

    // (c * level) >> 4; the product never exceeds 15*16 = 240, so bits [7:4] hold the result.
    function automatic logic [3:0] scale_channel(input logic [3:0] c, input level_t lvl);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, lvl};
        return prod[7:4];
    endfunction

endpackage

// File: rtl/vga_fade_ctrl.sv
// Power-up hold and stepped brightness fade FSM; drives the 0..16 level used by the output stage.
module vga_fade_ctrl
    import vga_layer_compositor_pkg::*;
#(
    parameter int HOLD_CYCLES      = 75_000_000,
    parameter int FADE_STEP_CYCLES = 1_562_500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fade_in_req,
    input  logic       fade_out_req,
    output logic [4:0] level,
    output logic [2:0] fade_state,
    output logic       fade_busy
);

    localparam int CNT_MAX = (HOLD_CYCLES > FADE_STEP_CYCLES) ? HOLD_CYCLES : FADE_STEP_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FADE_STEP_CYCLES - 1);

    fade_state_t      state, state_n;
    level_t           level_q, level_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= HOLD;
            level_q <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            level_q <= level_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        level_n = level_q;
        cnt_n   = cnt + 1'b1;
        step    = (cnt == STEP_LAST);
        case (state)
            HOLD: begin
                level_n = '0;
                if (cnt == HOLD_LAST) state_n = FADE_IN;
            end
            FADE_IN: begin
                // fade_out_req outranks everything, including a simultaneous fade_in_req.
                if (fade_out_req) begin
                    state_n = FADE_OUT;
                end else if (level_q >= LEVEL_MAX) begin
                    level_n = LEVEL_MAX;
                    state_n = ON;
                end else if (step) begin
                    cnt_n   = '0;
                    level_n = level_q + 1'b1;
                    if (level_n == LEVEL_MAX) state_n = ON;
                end
            end
            ON: begin
                level_n = LEVEL_MAX;
                cnt_n   = '0;
                if (fade_out_req) state_n = FADE_OUT;
            end
            FADE_OUT: begin
                if (fade_in_req && !fade_out_req) begin
                    state_n = FADE_IN;
                end else if (level_q == '0) begin
                    state_n = OFF;
                end else if (step) begin
                    cnt_n   = '0;
                    level_n = level_q - 1'b1;
                    if (level_n == '0) state_n = OFF;
                end
            end
            OFF: begin
                level_n = '0;
                cnt_n   = '0;
                if (fade_in_req && !fade_out_req) state_n = FADE_IN;
            end
            default: begin
                state_n = HOLD;
                level_n = '0;
            end
        endcase
        if (state_n != state) cnt_n = '0;
    end

    assign level      = level_q;
    assign fade_state = state;
    assign fade_busy  = (state == HOLD) || (state == FADE_IN) || (state == FADE_OUT);

endmodule

// File: rtl/vga_layer_compositor.sv
// Priority layer compositor with 2-stage pipeline and brightness fade.
// Define VGA_COMPOSITOR_COLORKEY_EN to make COLOR_KEY pixels transparent.
module vga_layer_compositor
    import vga_layer_compositor_pkg::*;
#(
    parameter int     NUM_LAYERS       = 16,
    parameter int     COLOR_W          = 12,
    parameter int     HOLD_CYCLES      = 75_000_000,
    parameter int     FADE_STEP_CYCLES = 1_562_500,
    parameter color_t COLOR_KEY        = 12'hF0F
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_LAYERS*COLOR_W-1:0]       layer_rgb,
    input  logic [NUM_LAYERS-1:0]               layer_drawing,
    input  logic [NUM_LAYERS-1:0]               layer_enable,
    input  logic                                video_on,
    input  logic                                fade_in_req,
    input  logic                                fade_out_req,
    output logic [COLOR_W-1:0]                  rgb_out,
    output logic [$clog2(NUM_LAYERS+1)-1:0]     layer_sel,
    output logic [2:0]                          fade_state,
    output logic                                fade_busy
);

    localparam int SEL_W = $clog2(NUM_LAYERS + 1);

`ifdef VGA_COMPOSITOR_COLORKEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic [4:0]             level;
    logic [NUM_LAYERS-1:0]  hit;
    logic [COLOR_W-1:0]     win_color;
    logic [SEL_W-1:0]       win_idx;
    logic [COLOR_W-1:0]     s1_color;
    logic [SEL_W-1:0]       s1_idx;
    logic                   s1_video;

    vga_fade_ctrl #(
        .HOLD_CYCLES      (HOLD_CYCLES),
        .FADE_STEP_CYCLES (FADE_STEP_CYCLES)
    ) u_fade (
        .clk          (clk),
        .reset        (reset),
        .fade_in_req  (fade_in_req),
        .fade_out_req (fade_out_req),
        .level        (level),
        .fade_state   (fade_state),
        .fade_busy    (fade_busy)
    );

    // Scan from the lowest priority upward so the lowest hitting index ends up as the winner.
    always_comb begin
        win_color = BLACK;
        win_idx   = SEL_W'(NUM_LAYERS);
        for (int i = 0; i < NUM_LAYERS; i++) begin
            hit[i] = layer_drawing[i] && layer_enable[i] &&
                     !(KEY_EN && (layer_rgb[i*COLOR_W +: COLOR_W] == COLOR_KEY));
        end
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_color = layer_rgb[i*COLOR_W +: COLOR_W];
                win_idx   = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_color  <= BLACK;
            s1_idx    <= SEL_W'(NUM_LAYERS);
            s1_video  <= 1'b0;
            rgb_out   <= '0;
            layer_sel <= SEL_W'(NUM_LAYERS);
        end else begin
            s1_color  <= win_color;
            s1_idx    <= win_idx;
            s1_video  <= video_on;
            layer_sel <= s1_idx;
            if (s1_video) begin
                rgb_out <= {scale_channel(s1_color[11:8], level),
                            scale_channel(s1_color[7:4],  level),
                            scale_channel(s1_color[3:0],  level)};
            end else begin
                rgb_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor with short hold/step timing and four layers.
module tb_vga_layer_compositor;
    import vga_layer_compositor_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 12;
    localparam int SW   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*CW-1:0] layer_rgb;
    logic [N-1:0]    layer_drawing;
    logic [N-1:0]    layer_enable;
    logic            video_on;
    logic            fade_in_req;
    logic            fade_out_req;
    logic [CW-1:0]   rgb_out;
    logic [SW-1:0]   layer_sel;
    logic [2:0]      fade_state;
    logic            fade_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    vga_layer_compositor #(
        .NUM_LAYERS       (N),
        .COLOR_W          (CW),
        .HOLD_CYCLES      (10),
        .FADE_STEP_CYCLES (2),
        .COLOR_KEY        (12'hF0F)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .layer_rgb     (layer_rgb),
        .layer_drawing (layer_drawing),
        .layer_enable  (layer_enable),
        .video_on      (video_on),
        .fade_in_req   (fade_in_req),
        .fade_out_req  (fade_out_req),
        .rgb_out       (rgb_out),
        .layer_sel     (layer_sel),
        .fade_state    (fade_state),
        .fade_busy     (fade_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_layer(input int i, input logic [CW-1:0] c);
        layer_rgb[i*CW +: CW] = c;
    endtask

    initial begin
        logic [3:0] exp_c;
        reset         = 1'b1;
        layer_rgb     = {N{12'hFFF}};
        layer_drawing = 4'hF;
        layer_enable  = 4'hF;
        video_on      = 1'b1;
        fade_in_req   = 1'b0;
        fade_out_req  = 1'b0;
        tick(3);

        check("rst_rgb",   rgb_out,    0);
        check("rst_sel",   layer_sel,  4);
        check("rst_state", fade_state, HOLD);
        check("rst_busy",  fade_busy,  1);

        // Hold phase: black for 10 clocks regardless of drawing layers
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("hold_state", fade_state, HOLD);
            check("hold_rgb",   rgb_out,    0);
            tick(1);
        end
        check("fadein_enter", fade_state, FADE_IN);
        check("fadein_busy",  fade_busy,  1);

        // Level k is reached 2k clocks into FADE_IN; rgb shows the previous level.
        // At level L>0 a full-scale channel becomes L-1 (15*L>>4).
        for (int k = 1; k <= 16; k++) begin
            tick(2);
            exp_c = (k - 1 == 0) ? 4'd0 : 4'(k - 2);
            check("ramp_rgb", rgb_out, {exp_c, exp_c, exp_c});
        end
        check("on_state", fade_state, ON);
        check("on_busy",  fade_busy,  0);
        tick(1);
        check("on_rgb", rgb_out,   12'hFFF);
        check("on_sel", layer_sel, 0);

        // Priority among layers 1 and 3
        layer_drawing = 4'b1010;
        set_layer(1, 12'h0F0);
        set_layer(3, 12'h00F);
        tick(1);
        check("prio_lat1", rgb_out, 12'hFFF);
        tick(1);
        check("prio_rgb", rgb_out,   12'h0F0);
        check("prio_sel", layer_sel, 1);
        layer_enable[1] = 1'b0;
        tick(2);
        check("mask_rgb", rgb_out,   12'h00F);
        check("mask_sel", layer_sel, 3);
        layer_drawing = 4'b0000;
        tick(2);
        check("bg_rgb", rgb_out,   12'h000);
        check("bg_sel", layer_sel, 4);
        layer_enable = 4'hF;

        // Key colour on layer 0 over layer 2
        set_layer(0, 12'hF0F);
        set_layer(2, 12'h123);
        layer_drawing = 4'b0101;
        tick(2);
`ifdef VGA_COMPOSITOR_COLORKEY_EN
        check("key_rgb", rgb_out,   12'h123);
        check("key_sel", layer_sel, 2);
`else
        check("key_rgb", rgb_out,   12'hF0F);
        check("key_sel", layer_sel, 0);
`endif

        // video_on blanking, 2-clock latency
        set_layer(0, 12'hF80);
        layer_drawing = 4'b0001;
        tick(2);
        check("f80_rgb", rgb_out, 12'hF80);
        video_on = 1'b0;
        tick(1);
        check("blank_lat1", rgb_out, 12'hF80);
        tick(1);
        check("blank_rgb", rgb_out,   12'h000);
        check("blank_sel", layer_sel, 0);
        video_on = 1'b1;
        tick(2);
        check("unblank_rgb", rgb_out, 12'hF80);

        // ON ignores fade_in_req
        fade_in_req = 1'b1;
        tick(1);
        fade_in_req = 1'b0;
        check("on_ign_in", fade_state, ON);

        // Fade out from ON: level 8 after 16 clocks, 0 after 32
        fade_out_req = 1'b1;
        tick(1);
        fade_out_req = 1'b0;
        check("fo_state", fade_state, FADE_OUT);
        check("fo_busy",  fade_busy,  1);
        tick(17);
        check("fo_lvl8_rgb", rgb_out, 12'h740);
        tick(15);
        check("off_state", fade_state, OFF);
        check("off_busy",  fade_busy,  0);
        tick(1);
        check("off_rgb", rgb_out, 12'h000);
        fade_out_req = 1'b1;
        tick(1);
        fade_out_req = 1'b0;
        check("off_ign_out", fade_state, OFF);

        // Re-fade-in, reverse at level 6
        set_layer(0, 12'hFFF);
        fade_in_req = 1'b1;
        tick(1);
        fade_in_req = 1'b0;
        check("refi_state", fade_state, FADE_IN);
        tick(12);
        fade_out_req = 1'b1;
        tick(1);
        fade_out_req = 1'b0;
        check("rev_state", fade_state, FADE_OUT);
        tick(1);
        check("rev_lvl6_a", rgb_out, 12'h555);
        tick(1);
        check("rev_lvl6_b", rgb_out, 12'h555);
        tick(1);
        check("rev_lvl5", rgb_out, 12'h444);

        // Back to FADE_IN, then simultaneous requests
        fade_in_req = 1'b1;
        tick(1);
        fade_in_req = 1'b0;
        check("fi_again", fade_state, FADE_IN);
        fade_in_req  = 1'b1;
        fade_out_req = 1'b1;
        tick(1);
        fade_in_req  = 1'b0;
        fade_out_req = 1'b0;
        check("both_req", fade_state, FADE_OUT);

        // Asynchronous reset in the middle of FADE_OUT
        tick(3);
        check("pre_rst_rgb_nz", (rgb_out != 12'h000), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_state", fade_state, HOLD);
        check("mid_rst_rgb",   rgb_out,    0);
        check("mid_rst_sel",   layer_sel,  4);
        check("mid_rst_busy",  fade_busy,  1);
        tick(1);
        reset = 1'b0;
        tick(2);
        check("post_rst_state", fade_state, HOLD);
        check("post_rst_rgb",   rgb_out,    0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
